// File: rtl/cic_interp_pkg.sv
// Shared types and constants for the 3-stage CIC interpolator.
// Sample/accumulator typedefs and the rate-select clamp.
package cic_interp_pkg;

  localparam int W        = 28;
  localparam int N_STAGES = 3;
  localparam int K_MAX    = 4;
  localparam int ACC_W    = W + N_STAGES * K_MAX;

  typedef logic signed [W-1:0]     sample_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic logic [2:0] clamp_k(
    input logic [2:0] sel
  );
    return (sel > 3'd4) ? 3'd4 : sel;
  endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Rounding arithmetic right shift by s, then saturation to W bits.
// Ports: din (acc), s (shift 0..8), dout (sample), sat (clipped).
module cic_round_sat
  import cic_interp_pkg::*;
(
  input  acc_t       din,
  input  logic [3:0] s,
  output sample_t    dout,
  output logic       sat
);

  // One guard bit so the rounding add never wraps.
  localparam int EW = ACC_W + 1;
  typedef logic signed [EW-1:0] ext_t;

  localparam ext_t MAXV = ext_t'((2 ** (W - 1)) - 1);
  localparam ext_t MINV = ext_t'(-(2 ** (W - 1)));

  ext_t rnd;
  ext_t sum;
  ext_t y;

  always_comb begin
    rnd = '0;
    if (s != 4'd0)
      rnd = ext_t'(1) <<< (s - 4'd1);
    sum  = ext_t'(din) + rnd;
    y    = sum >>> s;
    sat  = 1'b0;
    dout = sample_t'(y);
    if (y > MAXV) begin
      sat  = 1'b1;
      dout = sample_t'(MAXV);
    end else if (y < MINV) begin
      sat  = 1'b1;
      dout = sample_t'(MINV);
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// 3-stage CIC interpolator, R = 2^k outputs per input, unity gain.
// Ports: clk, reset, clk_enable, sync_reset, interp_sel, in_* / out_*
// valid/ready streams, ovf_flag (sticky, needs CIC_OVF_FLAG_EN).
module cic_interpolator
  import cic_interp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       sync_reset,
  input  logic [2:0] interp_sel,
  input  sample_t    in_sample,
  input  logic       in_valid,
  output logic       in_ready,
  output sample_t    out_sample,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf_flag
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

`ifdef CIC_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic [0:0]       state;
  logic [K_MAX-1:0] phase;
  logic [K_MAX-1:0] last_phase;
  logic [2:0]       k_reg;
  logic [3:0]       s;

  acc_t x_d1, c1_d, c2_d, u_reg;
  acc_t i1, i2, i3;
  acc_t c1, c2, c3;
  acc_t v, i1_n, i2_n, i3_n;

  logic    clr;
  logic    step;
  logic    emit_step;
  logic    last;
  logic    accept;
  sample_t y_sat;
  logic    y_ovf;

  assign clr        = reset || (clk_enable && sync_reset);
  assign step       = clk_enable && (!out_valid || out_ready);
  assign emit_step  = (state == EMIT) && step;
  assign last_phase = ~({K_MAX{1'b1}} << k_reg);
  assign last       = (phase == last_phase);
  assign s          = {k_reg, 1'b0};

  // A clearing cycle drops any handshake, so do not advertise ready.
  assign in_ready = clk_enable && !reset && !sync_reset &&
                    ((state == IDLE) || (last && emit_step));
  assign accept   = in_valid && in_ready;

  assign c1 = acc_t'(in_sample) - x_d1;
  assign c2 = c1 - c1_d;
  assign c3 = c2 - c2_d;

  // Zero-stuffing: only phase 0 feeds the comb output forward.
  assign v    = (phase == '0) ? u_reg : '0;
  assign i1_n = i1 + v;
  assign i2_n = i2 + i1_n;
  assign i3_n = i3 + i2_n;

  cic_round_sat u_round_sat (
    .din  (i3_n),
    .s    (s),
    .dout (y_sat),
    .sat  (y_ovf)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      phase      <= '0;
      k_reg      <= clamp_k(interp_sel);
      x_d1       <= '0;
      c1_d       <= '0;
      c2_d       <= '0;
      u_reg      <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      ovf_flag   <= 1'b0;
    end else if (clk_enable) begin
      if (accept) begin
        x_d1  <= acc_t'(in_sample);
        c1_d  <= c1;
        c2_d  <= c2;
        u_reg <= c3;
      end
      if (emit_step) begin
        i1         <= i1_n;
        i2         <= i2_n;
        i3         <= i3_n;
        out_sample <= y_sat;
        out_valid  <= 1'b1;
        ovf_flag   <= ovf_flag | (OVF_EN & y_ovf);
        if (last) begin
          phase <= '0;
          state <= accept ? EMIT : IDLE;
        end else begin
          phase <= phase + 1'b1;
        end
      end else begin
        if (accept) begin
          state <= EMIT;
          phase <= '0;
        end
        if (step)
          out_valid <= 1'b0;
      end
    end
  end

endmodule
